// File: rtl/vx_ti_ray_stack_pkg.sv
// Shared ray-traversal stack types and sizing constants, common to the
// traversal unit and its per-ray stacks.
package vx_ti_ray_stack_pkg;

  localparam int TI_STACK_DEPTH = 16;
  localparam int TI_DATA_WIDTH  = 32;
  localparam int TI_NUM_RAYS    = 4;

  typedef enum logic [1:0] {
    TI_OP_CLEAR = 2'd0,
    TI_OP_PUSH1 = 2'd1,
    TI_OP_PUSH2 = 2'd2,
    TI_OP_POP   = 2'd3
  } ti_stack_op_t;

  // A single context still needs a one-bit ray selector.
  function automatic int tiRayBits(input int numRays);
    return (numRays > 1) ? $clog2(numRays) : 1;
  endfunction

endpackage

// File: rtl/vx_ti_ray_stack_ctx.sv
// One ray's circular BVH node stack: storage, write pointer, count and sticky
// overflow. When full, a push overwrites the oldest (bottom) entry.
module vx_ti_ray_stack_ctx
  import vx_ti_ray_stack_pkg::*;
#(
  parameter int DEPTH      = TI_STACK_DEPTH,
  parameter int DATA_WIDTH = TI_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  opValid,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] topData,
  output logic                  empty,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL        = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_FULL = CNT_W'(DEPTH - 1);

  ti_stack_op_t          opType_s;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wrPtr_r;
  logic [PTR_W-1:0]      wrPtrInc1_s;
  logic [PTR_W-1:0]      wrPtrInc2_s;
  logic [PTR_W-1:0]      wrPtrDec_s;
  logic [CNT_W-1:0]      count_r;
  logic                  overflow_r;

  // wrPtr_r is the next free slot; power-of-two DEPTH makes the wrap implicit.
  assign opType_s    = ti_stack_op_t'(op);
  assign wrPtrInc1_s = wrPtr_r + PTR_W'(1);
  assign wrPtrInc2_s = wrPtr_r + PTR_W'(2);
  assign wrPtrDec_s  = wrPtr_r - PTR_W'(1);

  assign topData  = mem_r[wrPtrDec_s];
  assign empty    = (count_r == CNT_W'(0));
  assign overflow = overflow_r;

  // Entry storage: PUSH2 writes the far index first, the near index on top.
  always_ff @(posedge clk) begin
    if (opValid && (opType_s == TI_OP_PUSH1)) begin
      mem_r[wrPtr_r] <= data0;
    end else if (opValid && (opType_s == TI_OP_PUSH2)) begin
      mem_r[wrPtr_r]     <= data0;
      mem_r[wrPtrInc1_s] <= data1;
    end
  end

  // Pointer, saturating count and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_r    <= PTR_W'(0);
      count_r    <= CNT_W'(0);
      overflow_r <= 1'b0;
    end else if (opValid) begin
      case (opType_s)
        TI_OP_CLEAR: begin
          count_r    <= CNT_W'(0);
          overflow_r <= 1'b0;
        end
        TI_OP_PUSH1: begin
          wrPtr_r <= wrPtrInc1_s;
          if (count_r == FULL) begin
            overflow_r <= 1'b1;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        TI_OP_PUSH2: begin
          wrPtr_r <= wrPtrInc2_s;
          if (count_r >= ALMOST_FULL) begin
            count_r    <= FULL;
            overflow_r <= 1'b1;
          end else begin
            count_r <= count_r + CNT_W'(2);
          end
        end
        TI_OP_POP: begin
          if (count_r != CNT_W'(0)) begin
            wrPtr_r <= wrPtrDec_s;
            count_r <= count_r - CNT_W'(1);
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/vx_ti_ray_stack.sv
// Multi-ray traversal stack: routes one request per cycle to the addressed
// ray context and returns pop results through a registered valid/ready port.
module vx_ti_ray_stack
  import vx_ti_ray_stack_pkg::*;
#(
  parameter int  NUM_RAYS   = TI_NUM_RAYS,
  parameter int  DEPTH      = TI_STACK_DEPTH,
  parameter int  DATA_WIDTH = TI_DATA_WIDTH,
  localparam int RAY_BITS   = tiRayBits(NUM_RAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [RAY_BITS-1:0]   req_ray,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_data0,
  input  logic [DATA_WIDTH-1:0] req_data1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RAY_BITS-1:0]   rsp_ray,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_empty,
  output logic [NUM_RAYS-1:0]   ray_empty,
  output logic [NUM_RAYS-1:0]   ray_overflow
);

  logic                  fire_s;
  ti_stack_op_t          reqOp_s;
  logic [DATA_WIDTH-1:0] ctxTop_s [NUM_RAYS];
  logic [DATA_WIDTH-1:0] selTop_s;
  logic                  selEmpty_s;

  // A pending response blocks new requests so it is never overwritten.
  assign req_ready = !(rsp_valid && !rsp_ready);
  assign fire_s    = req_valid && req_ready;
  assign reqOp_s   = ti_stack_op_t'(req_op);

  for (genvar g = 0; g < NUM_RAYS; g++) begin : gCtx
    vx_ti_ray_stack_ctx #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) uCtx (
      .clk      (clk),
      .reset    (reset),
      .opValid  (fire_s && (req_ray == RAY_BITS'(g))),
      .op       (req_op),
      .data0    (req_data0),
      .data1    (req_data1),
      .topData  (ctxTop_s[g]),
      .empty    (ray_empty[g]),
      .overflow (ray_overflow[g])
    );
  end

  // Top entry and emptiness of the addressed ray; out-of-range rays read as empty.
  always_comb begin
    selTop_s   = {DATA_WIDTH{1'b0}};
    selEmpty_s = 1'b1;
    for (int i = 0; i < NUM_RAYS; i++) begin
      selTop_s   = (req_ray == RAY_BITS'(i)) ? ctxTop_s[i] : selTop_s;
      selEmpty_s = (req_ray == RAY_BITS'(i)) ? ray_empty[i] : selEmpty_s;
    end
  end

  // Pop response register; a new pop may replace a result consumed this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_ray   <= RAY_BITS'(0);
      rsp_data  <= {DATA_WIDTH{1'b0}};
      rsp_empty <= 1'b0;
    end else if (fire_s && (reqOp_s == TI_OP_POP)) begin
      rsp_valid <= 1'b1;
      rsp_ray   <= req_ray;
      rsp_empty <= selEmpty_s;
      rsp_data  <= selEmpty_s ? {DATA_WIDTH{1'b0}} : selTop_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

endmodule

// File: tb/tb_vx_ti_ray_stack.sv
// Self-checking bench for vx_ti_ray_stack against a queue-based stack model.
module tb_vx_ti_ray_stack;

  localparam int NR    = 4;
  localparam int DEPTH = 16;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_ray = 2'd0;
  logic [1:0]    req_op = 2'd0;
  logic [DW-1:0] req_data0 = '0;
  logic [DW-1:0] req_data1 = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [1:0]    rsp_ray;
  logic [DW-1:0] rsp_data;
  logic          rsp_empty;
  logic [NR-1:0] ray_empty;
  logic [NR-1:0] ray_overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mq [NR][$];
  bit            movf [NR];

  vx_ti_ray_stack #(.NUM_RAYS(NR), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_ray(req_ray), .req_op(req_op),
    .req_data0(req_data0), .req_data1(req_data1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ray(rsp_ray),
    .rsp_data(rsp_data), .rsp_empty(rsp_empty),
    .ray_empty(ray_empty), .ray_overflow(ray_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [NR-1:0] modelEmpty();
    logic [NR-1:0] e;
    for (int i = 0; i < NR; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  function automatic logic [NR-1:0] modelOvf();
    logic [NR-1:0] o;
    for (int i = 0; i < NR; i++) o[i] = movf[i];
    return o;
  endfunction

  function automatic void modelPush(input logic [1:0] r, input logic [DW-1:0] d);
    mq[r].push_back(d);
    if (mq[r].size() > DEPTH) begin
      void'(mq[r].pop_front());
      movf[r] = 1'b1;
    end
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NR; i++) begin
      mq[i].delete();
      movf[i] = 1'b0;
    end
  endfunction

  // Drive one request, let it fire, update the model, return the expected pop result.
  task automatic issue(input logic [1:0] ray, input logic [1:0] op,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       output logic [DW-1:0] eData, output logic eEmpty);
    int waitCyc;
    @(negedge clk);
    req_valid = 1'b1; req_ray = ray; req_op = op; req_data0 = d0; req_data1 = d1;
    waitCyc = 0;
    #1;
    while (!req_ready) begin
      if (waitCyc > 50) begin
        $display("FAIL issue_timeout: req_ready=%b, required 1", req_ready);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "bench aborted");
      end
      @(negedge clk); #1;
      waitCyc++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    eData = '0;
    eEmpty = 1'b0;
    case (op)
      2'd0: begin mq[ray].delete(); movf[ray] = 1'b0; end
      2'd1: modelPush(ray, d0);
      2'd2: begin modelPush(ray, d0); modelPush(ray, d1); end
      default: begin
        if (mq[ray].size() == 0) eEmpty = 1'b1;
        else eData = mq[ray].pop_back();
      end
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_data !== 32'd0) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    vectors++; if (rsp_empty !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_empty: got %b want 0", rsp_empty); end
    vectors++; if (rsp_ray !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_ray: got %0d want 0", rsp_ray); end
    vectors++; if (ray_empty !== 4'b1111) begin miscompares++; $display("FAIL reset_ray_empty: got %b want 1111", ray_empty); end
    vectors++; if (ray_overflow !== 4'b0000) begin miscompares++; $display("FAIL reset_ray_overflow: got %b want 0000", ray_overflow); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic test_basic();
    logic [DW-1:0] ed; logic ee;
    logic [DW-1:0] want [3];
    want[0] = 32'd9; want[1] = 32'd7; want[2] = 32'd5;
    issue(2'd0, 2'd1, 32'd5, 32'd0, ed, ee);
    issue(2'd0, 2'd2, 32'd7, 32'd9, ed, ee);
    for (int i = 0; i < 3; i++) begin
      issue(2'd0, 2'd3, 32'd0, 32'd0, ed, ee);
      vectors++; if (rsp_valid !== 1'b1 || rsp_data !== want[i] || rsp_empty !== 1'b0 || rsp_ray !== 2'd0) begin
        miscompares++; $display("FAIL basic_pop%0d: got v=%b d=%0d e=%b r=%0d want v=1 d=%0d e=0 r=0", i, rsp_valid, rsp_data, rsp_empty, rsp_ray, want[i]);
      end
    end
    vectors++; if (ray_empty[0] !== 1'b1) begin miscompares++; $display("FAIL basic_empty: got %b want 1", ray_empty[0]); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] ed; logic ee;
    for (int i = 1; i <= 17; i++) issue(2'd1, 2'd1, DW'(i), 32'd0, ed, ee);
    vectors++; if (ray_overflow !== modelOvf()) begin miscompares++; $display("FAIL ovf_set: got %b want %b", ray_overflow, modelOvf()); end
    for (int i = 0; i < 17; i++) begin
      issue(2'd1, 2'd3, 32'd0, 32'd0, ed, ee);
      vectors++; if (rsp_data !== ed || rsp_empty !== ee || rsp_ray !== 2'd1 || rsp_valid !== 1'b1) begin
        miscompares++; $display("FAIL ovf_pop%0d: got d=%0d e=%b r=%0d v=%b want d=%0d e=%b r=1 v=1", i, rsp_data, rsp_empty, rsp_ray, rsp_valid, ed, ee);
      end
    end
    vectors++; if (ray_overflow[1] !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", ray_overflow[1]); end
    issue(2'd1, 2'd0, 32'd0, 32'd0, ed, ee);
    vectors++; if (ray_overflow !== modelOvf() || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL ovf_clear: got ovf=%b v=%b want ovf=%b v=0", ray_overflow, rsp_valid, modelOvf());
    end
  endtask

  task automatic test_push2_wrap();
    logic [DW-1:0] ed; logic ee;
    for (int i = 1; i <= 15; i++) issue(2'd2, 2'd1, DW'(i), 32'd0, ed, ee);
    issue(2'd2, 2'd2, 32'd100, 32'd101, ed, ee);
    vectors++; if (ray_overflow[2] !== 1'b1 || ray_empty !== modelEmpty()) begin
      miscompares++; $display("FAIL wrap_flags: got ovf=%b emp=%b want ovf2=1 emp=%b", ray_overflow, ray_empty, modelEmpty());
    end
    for (int i = 0; i < 17; i++) begin
      issue(2'd2, 2'd3, 32'd0, 32'd0, ed, ee);
      vectors++; if (rsp_data !== ed || rsp_empty !== ee || rsp_ray !== 2'd2) begin
        miscompares++; $display("FAIL wrap_pop%0d: got d=%0d e=%b r=%0d want d=%0d e=%b r=2", i, rsp_data, rsp_empty, rsp_ray, ed, ee);
      end
    end
  endtask

  task automatic test_interleave();
    logic [DW-1:0] ed; logic ee;
    issue(2'd0, 2'd1, 32'hA, 32'd0, ed, ee);
    issue(2'd3, 2'd1, 32'hB, 32'd0, ed, ee);
    issue(2'd3, 2'd3, 32'd0, 32'd0, ed, ee);
    vectors++; if (rsp_data !== 32'hB || rsp_ray !== 2'd3 || rsp_empty !== 1'b0) begin
      miscompares++; $display("FAIL inter_r3: got d=%h r=%0d e=%b want d=b r=3 e=0", rsp_data, rsp_ray, rsp_empty);
    end
    issue(2'd0, 2'd3, 32'd0, 32'd0, ed, ee);
    vectors++; if (rsp_data !== 32'hA || rsp_ray !== 2'd0 || rsp_empty !== 1'b0) begin
      miscompares++; $display("FAIL inter_r0: got d=%h r=%0d e=%b want d=a r=0 e=0", rsp_data, rsp_ray, rsp_empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ed; logic ee;
    issue(2'd3, 2'd2, 32'h31, 32'h32, ed, ee);
    issue(2'd3, 2'd2, 32'h33, 32'h34, ed, ee);
    for (int i = 0; i < 4; i++) begin
      issue(2'd3, 2'd3, 32'd0, 32'd0, ed, ee);
      vectors++; if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_empty !== ee) begin
        miscompares++; $display("FAIL b2b_pop%0d: got v=%b d=%h e=%b want v=1 d=%h e=%b", i, rsp_valid, rsp_data, rsp_empty, ed, ee);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ed; logic ee;
    logic [DW-1:0] held;
    issue(2'd1, 2'd1, 32'h11, 32'd0, ed, ee);
    issue(2'd1, 2'd1, 32'h22, 32'd0, ed, ee);
    rsp_ready = 1'b0;
    issue(2'd1, 2'd3, 32'd0, 32'd0, ed, ee);
    held = ed;
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== held) begin
      miscompares++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_data, held);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_ray = 2'd1; req_op = 2'd1; req_data0 = 32'h99;
      #1;
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready%0d: got %b want 0", c, req_ready); end
      @(posedge clk); #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_ray !== 2'd1 || rsp_empty !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold%0d: got v=%b d=%h r=%0d e=%b want v=1 d=%h r=1 e=0", c, rsp_valid, rsp_data, rsp_ray, rsp_empty, held);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    issue(2'd1, 2'd3, 32'd0, 32'd0, ed, ee);
    vectors++; if (rsp_data !== ed || rsp_empty !== ee) begin
      miscompares++; $display("FAIL bp_nopush: got d=%h e=%b want d=%h e=%b", rsp_data, rsp_empty, ed, ee);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] ed; logic ee;
    logic [1:0] ray, op;
    int r;
    for (int n = 0; n < 400; n++) begin
      ray = 2'($urandom_range(0, NR - 1));
      r = $urandom_range(0, 19);
      op = (r == 0) ? 2'd0 : (r < 8) ? 2'd1 : (r < 11) ? 2'd2 : 2'd3;
      issue(ray, op, $urandom, $urandom, ed, ee);
      vectors++; if (rsp_valid !== (op == 2'd3)) begin
        miscompares++; $display("FAIL rnd_valid%0d: got %b want %b", n, rsp_valid, (op == 2'd3));
      end
      if (op == 2'd3) begin
        vectors++; if (rsp_data !== ed || rsp_empty !== ee || rsp_ray !== ray) begin
          miscompares++; $display("FAIL rnd_pop%0d: got d=%h e=%b r=%0d want d=%h e=%b r=%0d", n, rsp_data, rsp_empty, rsp_ray, ed, ee, ray);
        end
      end
      vectors++; if (ray_empty !== modelEmpty() || ray_overflow !== modelOvf()) begin
        miscompares++; $display("FAIL rnd_flags%0d: got emp=%b ovf=%b want emp=%b ovf=%b", n, ray_empty, ray_overflow, modelEmpty(), modelOvf());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] ed; logic ee;
    for (int i = 0; i < 17; i++) issue(2'd0, 2'd1, DW'(i + 50), 32'd0, ed, ee);
    issue(2'd2, 2'd1, 32'h77, 32'd0, ed, ee);
    issue(2'd2, 2'd3, 32'd0, 32'd0, ed, ee);
    vectors++; if (rsp_valid !== 1'b1 || ray_overflow[0] !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_pre: got v=%b ovf0=%b want v=1 ovf0=1", rsp_valid, ray_overflow[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    modelReset();
    vectors++; if (rsp_valid !== 1'b0 || ray_empty !== 4'b1111 || ray_overflow !== 4'b0000) begin
      miscompares++; $display("FAIL rstmid: got v=%b emp=%b ovf=%b want v=0 emp=1111 ovf=0000", rsp_valid, ray_empty, ray_overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_push2_wrap();
    test_interleave();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
